// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR pseudo-random source: maximal-length tap
// table, draw FSM state encoding, the advance function and the power-of-two
// mask helper used by the bounded-draw logic.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } fsm_t;

  // Maximal-length Fibonacci taps indexed by register width. Bit n of an entry
  // set means state bit n feeds the XOR. Entries 0..2 are unused.
  localparam logic [31:0] TAPS [33] = '{
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000,  //  0..2
    32'h0000_0006, 32'h0000_000C, 32'h0000_0014,  //  3..5
    32'h0000_0030, 32'h0000_0060, 32'h0000_00B8,  //  6..8
    32'h0000_0110, 32'h0000_0240, 32'h0000_0500,  //  9..11
    32'h0000_0829, 32'h0000_100D, 32'h0000_2015,  // 12..14
    32'h0000_6000, 32'h0000_D008, 32'h0001_2000,  // 15..17
    32'h0002_0400, 32'h0004_0023, 32'h0009_0000,  // 18..20
    32'h0014_0000, 32'h0030_0000, 32'h0042_0000,  // 21..23
    32'h00E1_0000, 32'h0120_0000, 32'h0200_0023,  // 24..26
    32'h0400_0013, 32'h0900_0000, 32'h1400_0000,  // 27..29
    32'h2000_0029, 32'h4800_0000, 32'h8020_0003   // 30..32
  };

  // One Fibonacci step: shift left, feedback parity of the tapped bits into bit 0.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s, input int width);
    logic [31:0] keep;
    logic        fb;
    keep = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
    fb   = ^(s & TAPS[width[5:0]]);
    return ((s << 1) | {31'b0, fb}) & keep;
  endfunction

  // Smallest (2^k)-1 that covers lim-1; all-ones when lim is zero (full range).
  function automatic logic [31:0] pow2_mask(input logic [31:0] lim);
    logic [31:0] m;
    if (lim == '0) begin
      m = '1;
    end else begin
      m = '0;
      for (int i = 0; i < 32; i++) begin
        if (m < lim - 32'd1) m = {m[30:0], 1'b1};
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register: advance, runtime seed load (zero seed replaced by the
// default seed) and recovery from an all-zero state.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'h0F)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_adv;
  logic [WIDTH-1:0] seed_eff;

  // Next-state candidates: the advanced value and the guarded seed.
  always_comb begin
    state_adv = WIDTH'(lfsr_next(32'(state), WIDTH));
    seed_eff  = (seed_in == '0) ? SEED : seed_in;
  end

  // State register; a load beats the zero guard, which beats the advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SEED;
    end else if (seed_load) begin
      state <= seed_eff;
    end else if (state == '0) begin
      state <= SEED;
    end else if (adv) begin
      state <= state_adv;
    end
  end

endmodule

// File: rtl/lfsr_prng.sv
// Parametrised LFSR pseudo-random source with a bounded-draw handshake that
// returns a uniform value in [0, limit-1] by rejection sampling.
// Optional period monitor (period_wrap / period_cnt) is built when the macro
// LFSR_PRNG_PERIOD_MON_EN is defined.
module lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(8'h0F),
  parameter int               OUT_W     = 8,
  parameter int               MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state,
  input  logic             req,
  input  logic [OUT_W-1:0] limit,
  output logic             busy,
  output logic             rnd_valid,
  output logic [OUT_W-1:0] rnd_value
`ifdef LFSR_PRNG_PERIOD_MON_EN
  ,
  output logic             period_wrap,
  output logic [WIDTH-1:0] period_cnt
`endif
);

  localparam int               TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  fsm_t             fsm;
  logic [OUT_W-1:0] lim_q;
  logic [OUT_W-1:0] mask_q;
  logic [OUT_W-1:0] cand;
  logic [TRY_W-1:0] tries;
  logic             adv;

  // The generator free-runs on en and is also stepped once per draw attempt.
  assign adv  = en | (fsm == DRAW);
  assign cand = state[OUT_W-1:0] & mask_q;

  lfsr_core #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .adv       (adv),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .state     (state)
  );

  // Draw FSM: accept a request, try candidates until one fits under the limit
  // or the attempt budget runs out, then pulse rnd_valid for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm       <= IDLE;
      lim_q     <= '0;
      mask_q    <= '0;
      tries     <= '0;
      busy      <= 1'b0;
      rnd_valid <= 1'b0;
      rnd_value <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (req) begin
            lim_q  <= limit;
            mask_q <= OUT_W'(pow2_mask(32'(limit)));
            tries  <= '0;
            busy   <= 1'b1;
            fsm    <= DRAW;
          end
        end
        DRAW: begin
          if (lim_q == '0 || cand < lim_q) begin
            rnd_value <= cand;
            rnd_valid <= 1'b1;
            fsm       <= DONE;
          end else if (tries == LAST_TRY) begin
            // Dropping the top mask bit always lands below the limit.
            rnd_value <= cand & (mask_q >> 1);
            rnd_valid <= 1'b1;
            fsm       <= DONE;
          end else begin
            tries <= tries + 1'b1;
          end
        end
        DONE: begin
          rnd_valid <= 1'b0;
          busy      <= 1'b0;
          fsm       <= IDLE;
        end
        default: begin
          rnd_valid <= 1'b0;
          busy      <= 1'b0;
          fsm       <= IDLE;
        end
      endcase
    end
  end

`ifdef LFSR_PRNG_PERIOD_MON_EN
  logic [WIDTH-1:0] mon_seed;
  logic [WIDTH-1:0] mon_next;

  // Value the state takes if this cycle's advance goes ahead.
  always_comb mon_next = WIDTH'(lfsr_next(32'(state), WIDTH));

  // Period monitor: count advances since the last load and flag the return
  // to the most recently loaded seed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mon_seed    <= SEED;
      period_cnt  <= '0;
      period_wrap <= 1'b0;
    end else if (seed_load) begin
      mon_seed    <= (seed_in == '0) ? SEED : seed_in;
      period_cnt  <= '0;
      period_wrap <= 1'b0;
    end else if (adv && state != '0) begin
      if (mon_next == mon_seed) begin
        period_wrap <= 1'b1;
        period_cnt  <= '0;
      end else begin
        period_wrap <= 1'b0;
        period_cnt  <= period_cnt + 1'b1;
      end
    end else begin
      period_wrap <= 1'b0;
    end
  end
`endif

endmodule
